// File: rtl/fp8_mul_arbiter.sv
// Round-robin scheduler sharing one combinational E4M3 multiplier across NREQ requesters.
// Optional build macro FP8_ZERO_BYPASS_EN forces exact signed-zero products at response capture.
module fp8_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [7:0]        mul_p,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_data,
  output logic              busy,
  output logic [CNTW-1:0]   op_count
);

  logic            s1_valid_q, s1_valid_d;
  logic [7:0]      mul_a_q, mul_a_d;
  logic [7:0]      mul_b_q, mul_b_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [CNTW-1:0] op_count_q, op_count_d;
  logic [IDW-1:0]  rr_last_q, rr_last_d;

  logic            s2_adv;
  logic            s1_adv;
  logic            s1_free;
  logic [NREQ-1:0] req_rot;
  logic            grant_hit;
  int              grant_off;
  logic [IDW-1:0]  grant_id;
  logic            take;
  logic [7:0]      sel_a;
  logic [7:0]      sel_b;
  logic [7:0]      cap_data;

  always_comb begin
    s2_adv  = ena & (~rsp_valid_q | rsp_ready);
    s1_adv  = s1_valid_q & s2_adv;
    s1_free = ena & (~s1_valid_q | s2_adv);
  end

  // Rotate so bit 0 is the requester just after rr_last; the lowest set bit wins.
  always_comb begin
    grant_hit = 1'b0;
    grant_off = 0;
    req_rot   = NREQ'({req_valid, req_valid} >> (int'(rr_last_q) + 1));
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        grant_hit = 1'b1;
        grant_off = i;
      end
    end
    grant_id = IDW'((int'(rr_last_q) + 1 + grant_off) % NREQ);
  end

  always_comb begin
    take      = s1_free & grant_hit;
    req_ready = '0;
    if (take) begin
      req_ready = NREQ'(1) << grant_id;
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a = req_a[8*i +: 8];
        sel_b = req_b[8*i +: 8];
      end
    end
  end

  // The shared multiplier mishandles exact zeros; the bypass substitutes a signed zero.
  always_comb begin
`ifdef FP8_ZERO_BYPASS_EN
    if ((mul_a_q[6:0] == 7'd0) || (mul_b_q[6:0] == 7'd0)) begin
      cap_data = {mul_a_q[7] ^ mul_b_q[7], 7'd0};
    end else begin
      cap_data = mul_p;
    end
`else
    cap_data = mul_p;
`endif
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    s1_id_d     = s1_id_q;
    rr_last_d   = rr_last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    op_count_d  = op_count_q;

    if (take) begin
      s1_valid_d = 1'b1;
      mul_a_d    = sel_a;
      mul_b_d    = sel_b;
      s1_id_d    = grant_id;
      rr_last_d  = grant_id;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      rsp_valid_d = s1_valid_q;
      rsp_id_d    = s1_id_q;
      rsp_data_d  = cap_data;
    end

    if (ena && rsp_valid_q && rsp_ready && (op_count_q != {CNTW{1'b1}})) begin
      op_count_d = op_count_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      s1_id_q     <= '0;
      rr_last_q   <= IDW'(NREQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      op_count_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      s1_id_q     <= s1_id_d;
      rr_last_q   <= rr_last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      op_count_q  <= op_count_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;
  assign busy      = s1_valid_q | rsp_valid_q;

endmodule

// File: tb/tb_fp8_mul_arbiter.sv
// Bench for fp8_mul_arbiter: behavioural E4M3 multiplier on mul_p, queue-based reference model,
// directed scenarios plus randomized traffic; a second instance uses a 4-bit op counter.
module tb_fp8_mul_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a = '0;
  logic [8*NREQ-1:0] req_b = '0;
  logic [7:0]        mul_a, mul_b, mul_p;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_data;
  logic              busy;
  logic [CNTW-1:0]   op_count;

  logic [NREQ-1:0]   s_req_ready;
  logic [7:0]        s_mul_a, s_mul_b, s_mul_p;
  logic              s_rsp_valid;
  logic [IDW-1:0]    s_rsp_id;
  logic [7:0]        s_rsp_data;
  logic              s_busy;
  logic [3:0]        s_op_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Approximate E4M3 multiplier: every operand treated as normalised, no zero handling.
  function automatic logic [7:0] fp8_mul(input logic [7:0] a, input logic [7:0] b);
    int e;
    int m;
    m = (8 + int'(a[2:0])) * (8 + int'(b[2:0]));
    e = int'(a[6:3]) + int'(b[6:3]) - 7;
    if (m >= 128) begin
      e = e + 1;
      m = m >> 4;
    end else begin
      m = m >> 3;
    end
    if (e < 0) return {a[7] ^ b[7], 7'd0};
    if (e > 15) return {a[7] ^ b[7], 7'h7E};
    return {a[7] ^ b[7], 4'(e), 3'(m)};
  endfunction

  function automatic logic [7:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
`ifdef FP8_ZERO_BYPASS_EN
    if ((a[6:0] == 7'd0) || (b[6:0] == 7'd0)) return {a[7] ^ b[7], 7'd0};
`endif
    return fp8_mul(a, b);
  endfunction

  assign mul_p   = fp8_mul(mul_a, mul_b);
  assign s_mul_p = fp8_mul(s_mul_a, s_mul_b);

  fp8_mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .op_count(op_count)
  );

  fp8_mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req_valid(req_valid), .req_ready(s_req_ready), .req_a(req_a), .req_b(req_b),
    .mul_a(s_mul_a), .mul_b(s_mul_b), .mul_p(s_mul_p),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_data(s_rsp_data),
    .busy(s_busy), .op_count(s_op_count)
  );

  // Reference: in-flight ops form a queue of depth 2; an op becomes visible one enabled edge after acceptance.
  typedef struct {
    int         id;
    logic [7:0] p;
    bit         old;
  } op_t;

  op_t        q[$];
  int         rr = NREQ - 1;
  int         cnt = 0;
  int         cnt_sat = 0;
  logic [NREQ-1:0] m_ready;
  bit         m_vis;
  int         m_id;
  logic [7:0] m_data;
  bit         m_busy;
  int         m_gnt;
  int         obs_gnt;
  int         obs_rsp;

  task automatic cyc_begin();
    #1;
    m_vis  = (q.size() > 0) && q[0].old;
    m_id   = m_vis ? q[0].id : 0;
    m_data = m_vis ? q[0].p : 8'h00;
    m_busy = (q.size() > 0);
    m_gnt  = -1;
    m_ready = '0;
    if (ena && ((q.size() < 2) || rsp_ready)) begin
      for (int k = 1; k <= NREQ; k++) begin
        if ((m_gnt < 0) && req_valid[(rr + k) % NREQ]) m_gnt = (rr + k) % NREQ;
      end
      if (m_gnt >= 0) m_ready[m_gnt] = 1'b1;
    end
    obs_gnt = -1;
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) obs_gnt = i;
    obs_rsp = (rsp_valid && rsp_ready && ena) ? int'(rsp_id) : -1;
  endtask

  task automatic cyc_end();
    bit  fire;
    op_t e;
    if (!rst_n) begin
      q.delete();
      rr = NREQ - 1;
      cnt = 0;
      cnt_sat = 0;
    end else if (ena) begin
      fire = m_vis && rsp_ready;
      foreach (q[i]) q[i].old = 1'b1;
      if (fire) begin
        void'(q.pop_front());
        if (cnt < 65535) cnt++;
        if (cnt_sat < 15) cnt_sat++;
      end
      if (m_gnt >= 0) begin
        e.id  = m_gnt;
        e.p   = ref_prod(req_a[8*m_gnt +: 8], req_b[8*m_gnt +: 8]);
        e.old = 1'b0;
        q.push_back(e);
        rr = m_gnt;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_op();
    if ($urandom_range(0, 7) == 0) return {1'($urandom), 7'd0};
    return 8'($urandom);
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    cyc_begin();
    cyc_end();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ena = 1'b1;
    apply_reset();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b want=0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (op_count !== '0) begin bad++; $display("FAIL reset_op_count got=%0d want=0", op_count); end
    total++; if ({mul_a, mul_b} !== 16'h0) begin bad++; $display("FAIL reset_mul_ab got=%h want=0000", {mul_a, mul_b}); end
    total++; if ({rsp_id, rsp_data} !== 10'h0) begin bad++; $display("FAIL reset_rsp_id_data got=%h want=0", {rsp_id, rsp_data}); end
    total++; if (s_op_count !== 4'd0) begin bad++; $display("FAIL reset_sat_count got=%0d want=0", s_op_count); end
  endtask

  task automatic test_single_op();
    apply_reset();
    rsp_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    req_a[7:0] = 8'h38;
    req_b[7:0] = 8'h40;
    req_valid = 4'b0001;
    cyc_begin();
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b want=0001", req_ready); end
    cyc_end();
    req_valid = '0;
    cyc_begin();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_rsp got=%0b want=0", rsp_valid); end
    cyc_end();
    cyc_begin();
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid got=%0b want=1", rsp_valid); end
    total++; if (rsp_data !== 8'h40) begin bad++; $display("FAIL single_rsp_data got=%h want=40", rsp_data); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL single_rsp_id got=%0d want=0", rsp_id); end
    cyc_end();
    cyc_begin();
    total++; if (op_count !== 16'd1) begin bad++; $display("FAIL single_op_count got=%0d want=1", op_count); end
    cyc_end();
  endtask

  task automatic test_round_robin();
    int g[8];
    int r[8];
    int exp_g[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_a[8*i +: 8] = rand_op();
        req_b[8*i +: 8] = rand_op();
      end
      cyc_begin();
      g[t] = obs_gnt;
      r[t] = obs_rsp;
      if (m_vis) begin
        total++; if (rsp_data !== m_data) begin bad++; $display("FAIL rr_data t=%0d got=%h want=%h", t, rsp_data, m_data); end
      end
      cyc_end();
    end
    req_valid = '0;
    for (int t = 0; t < 5; t++) begin
      total++; if (g[t] !== exp_g[t]) begin bad++; $display("FAIL rr_grant t=%0d got=%0d want=%0d", t, g[t], exp_g[t]); end
    end
    for (int t = 2; t < 8; t++) begin
      total++; if (r[t] !== (t - 2) % NREQ) begin bad++; $display("FAIL rr_rsp_id t=%0d got=%0d want=%0d", t, r[t], (t - 2) % NREQ); end
    end
  endtask

  task automatic test_backpressure();
    int g[7];
    logic [7:0] p1, p2;
    apply_reset();
    rsp_ready = 1'b0;
    req_a[15:8] = 8'h3C; req_b[15:8] = 8'h44;
    req_a[23:16] = 8'h48; req_b[23:16] = 8'hB8;
    p1 = ref_prod(8'h3C, 8'h44);
    p2 = ref_prod(8'h48, 8'hB8);
    req_valid = 4'b0110;
    for (int t = 0; t < 7; t++) begin
      cyc_begin();
      g[t] = obs_gnt;
      if (t >= 2) begin
        total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, p1}) begin
          bad++; $display("FAIL bp_hold t=%0d got=%0b/%0d/%h want=1/1/%h", t, rsp_valid, rsp_id, rsp_data, p1);
        end
      end
      cyc_end();
      if (g[t] >= 0) req_valid[g[t]] = 1'b0;
    end
    total++; if (g[0] !== 1) begin bad++; $display("FAIL bp_grant0 got=%0d want=1", g[0]); end
    total++; if (g[1] !== 2) begin bad++; $display("FAIL bp_grant1 got=%0d want=2", g[1]); end
    for (int t = 2; t < 7; t++) begin
      total++; if (g[t] !== -1) begin bad++; $display("FAIL bp_no_grant t=%0d got=%0d want=-1", t, g[t]); end
    end
    rsp_ready = 1'b1;
    cyc_begin();
    total++; if (obs_rsp !== 1) begin bad++; $display("FAIL bp_drain_first got=%0d want=1", obs_rsp); end
    cyc_end();
    cyc_begin();
    total++; if (obs_rsp !== 2) begin bad++; $display("FAIL bp_drain_second got=%0d want=2", obs_rsp); end
    total++; if (rsp_data !== p2) begin bad++; $display("FAIL bp_drain_data got=%h want=%h", rsp_data, p2); end
    cyc_end();
    cyc_begin();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0b want=0", rsp_valid); end
    cyc_end();
  endtask

  task automatic test_zero_bypass();
    bit seen = 1'b0;
    int g;
    rsp_ready = 1'b1;
    req_a[31:24] = 8'h00;
    req_b[31:24] = 8'hC0;
    req_valid = 4'b1000;
    for (int t = 0; t < 8 && !seen; t++) begin
      cyc_begin();
      g = obs_gnt;
      if (rsp_valid && (rsp_id == 2'd3)) begin
        seen = 1'b1;
`ifdef FP8_ZERO_BYPASS_EN
        total++; if (rsp_data !== 8'h80) begin bad++; $display("FAIL zero_bypass got=%h want=80", rsp_data); end
`else
        total++; if (rsp_data !== 8'h88) begin bad++; $display("FAIL zero_nobypass got=%h want=88", rsp_data); end
`endif
      end
      cyc_end();
      if (g == 3) req_valid = '0;
    end
    req_valid = '0;
    if (!seen) begin
      total++; bad++; $display("FAIL zero_timeout got=none want=response");
    end
  endtask

  task automatic test_ena();
    int ids[$];
    apply_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int t = 0; t < 14; t++) begin
      ena = !(t >= 4 && t <= 6);
      cyc_begin();
      if (!ena) begin
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL ena_ready t=%0d got=%b want=0000", t, req_ready); end
        total++; if ({rsp_valid, op_count} !== {m_vis, CNTW'(cnt)}) begin
          bad++; $display("FAIL ena_hold t=%0d got=%0b/%0d want=%0b/%0d", t, rsp_valid, op_count, m_vis, cnt);
        end
      end
      if (obs_rsp >= 0) ids.push_back(obs_rsp);
      cyc_end();
    end
    ena = 1'b1;
    req_valid = '0;
    total++; if (ids.size() !== 9) begin bad++; $display("FAIL ena_rsp_count got=%0d want=9", ids.size()); end
    foreach (ids[k]) begin
      total++; if (ids[k] !== k % NREQ) begin bad++; $display("FAIL ena_rsp_order k=%0d got=%0d want=%0d", k, ids[k], k % NREQ); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      ena = ($urandom_range(0, 9) != 0);
      rsp_ready = ($urandom_range(0, 9) < 7);
      req_valid = 4'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_a[8*i +: 8] = rand_op();
        req_b[8*i +: 8] = rand_op();
      end
      cyc_begin();
      total++; if (req_ready !== m_ready) begin bad++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, req_ready, m_ready); end
      total++; if (rsp_valid !== m_vis) begin bad++; $display("FAIL rnd_rsp_valid n=%0d got=%0b want=%0b", n, rsp_valid, m_vis); end
      if (m_vis) begin
        total++; if (int'(rsp_id) !== m_id) begin bad++; $display("FAIL rnd_rsp_id n=%0d got=%0d want=%0d", n, rsp_id, m_id); end
        total++; if (rsp_data !== m_data) begin bad++; $display("FAIL rnd_rsp_data n=%0d got=%h want=%h", n, rsp_data, m_data); end
      end
      total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy n=%0d got=%0b want=%0b", n, busy, m_busy); end
      total++; if (op_count !== CNTW'(cnt)) begin bad++; $display("FAIL rnd_op_count n=%0d got=%0d want=%0d", n, op_count, cnt); end
      cyc_end();
    end
    ena = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_reset_midop();
    apply_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    for (int t = 0; t < 3; t++) begin
      cyc_begin();
      cyc_end();
    end
    cyc_begin();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midop_full got=%0b want=1", busy); end
    cyc_end();
    rst_n = 1'b0;
    req_valid = '0;
    cyc_begin();
    cyc_end();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midop_rsp_valid got=%0b want=0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midop_busy got=%0b want=0", busy); end
    total++; if (op_count !== '0) begin bad++; $display("FAIL midop_op_count got=%0d want=0", op_count); end
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      cyc_begin();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midop_stray t=%0d got=%0b want=0", t, rsp_valid); end
      cyc_end();
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int t = 0; t < 26; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_a[8*i +: 8] = rand_op();
        req_b[8*i +: 8] = rand_op();
      end
      cyc_begin();
      total++; if (s_op_count !== 4'(cnt_sat)) begin bad++; $display("FAIL sat_count t=%0d got=%0d want=%0d", t, s_op_count, cnt_sat); end
      total++; if ({s_req_ready, s_rsp_valid, s_busy} !== {m_ready, m_vis, m_busy}) begin
        bad++; $display("FAIL sat_ctrl t=%0d got=%b/%0b/%0b want=%b/%0b/%0b", t, s_req_ready, s_rsp_valid, s_busy, m_ready, m_vis, m_busy);
      end
      if (m_vis) begin
        total++; if ({s_rsp_id, s_rsp_data} !== {IDW'(m_id), m_data}) begin
          bad++; $display("FAIL sat_rsp t=%0d got=%0d/%h want=%0d/%h", t, s_rsp_id, s_rsp_data, m_id, m_data);
        end
      end
      if (t == 22) begin
        total++; if (s_op_count !== 4'd15) begin bad++; $display("FAIL sat_reached got=%0d want=15", s_op_count); end
      end
      cyc_end();
    end
    cyc_begin();
    total++; if (s_op_count !== 4'd15) begin bad++; $display("FAIL sat_held got=%0d want=15", s_op_count); end
    total++; if (op_count !== 16'd24) begin bad++; $display("FAIL sat_wide_count got=%0d want=24", op_count); end
    cyc_end();
    req_valid = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_zero_bypass();
    test_ena();
    test_random();
    test_reset_midop();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
